// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
// Included by the arbiter top and its round-robin grant sub-module.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational pick from the valids, with the
// last winner remembered so that a tie goes to the other requester.
module rr_arbiter2
    import addsub_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_en,
    output logic o_grant0,
    output logic o_grant1,
    output logic o_grant_id
);

    logic r_last_grant;
    logic w_grant_id;

    always_comb begin
        w_grant_id = REQ0;
        if (i_valid0 && i_valid1) begin
            w_grant_id = ~r_last_grant;
        end else if (i_valid1) begin
            w_grant_id = REQ1;
        end
    end

    assign o_grant0   = i_valid0 && (w_grant_id == REQ0);
    assign o_grant1   = i_valid1 && (w_grant_id == REQ1);
    assign o_grant_id = w_grant_id;

    // Starting at REQ1 makes requester 0 win the first tie after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= REQ1;
        end else if (i_en) begin
            r_last_grant <= w_grant_id;
        end
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Shares one external add/sub datapath between two valid/ready requesters:
// grant, drive registered operands for one cycle, capture and return result.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH:0]   rsp0_result,
    input  logic             rsp0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH:0]   rsp1_result,
    input  logic             rsp1_ready,

    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_sub,
    input  logic [WIDTH:0]   au_result,

    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] op_count
);

    state_t           r_state;
    logic [WIDTH-1:0] r_au_a;
    logic [WIDTH-1:0] r_au_b;
    logic             r_au_sub;
    logic [WIDTH:0]   r_result;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic             r_grant_id;
    logic [CNT_W-1:0] r_op_count;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_gid;
    logic w_accept;
    logic w_rsp_done;

    assign w_idle = (r_state == IDLE);

    rr_arbiter2 u_rr (
        .i_clk      (CLOCK_50),
        .i_rst_n    (RESET_N),
        .i_valid0   (req0_valid),
        .i_valid1   (req1_valid),
        .i_en       (w_accept),
        .o_grant0   (w_grant0),
        .o_grant1   (w_grant1),
        .o_grant_id (w_gid)
    );

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_accept   = req0_ready || req1_ready;
    assign w_rsp_done = (r_state == RESP) &&
                        ((r_grant_id == REQ1) ? rsp1_ready : rsp0_ready);

    assign au_a     = r_au_a;
    assign au_b     = r_au_b;
    assign au_sub   = r_au_sub;
    assign busy     = !w_idle;
    assign grant_id = r_grant_id;
    assign op_count = r_op_count;

    // Result is only exposed on the side currently holding a valid response.
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_result = r_rsp0_valid ? r_result : '0;
    assign rsp1_result = r_rsp1_valid ? r_result : '0;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_au_a       <= '0;
            r_au_b       <= '0;
            r_au_sub     <= 1'b0;
            r_result     <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_grant_id   <= REQ0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_au_a     <= (w_gid == REQ1) ? req1_a   : req0_a;
                        r_au_b     <= (w_gid == REQ1) ? req1_b   : req0_b;
                        r_au_sub   <= (w_gid == REQ1) ? req1_sub : req0_sub;
                        r_grant_id <= w_gid;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_result     <= au_result;
                    r_rsp0_valid <= (r_grant_id == REQ0);
                    r_rsp1_valid <= (r_grant_id == REQ1);
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_op_count   <= r_op_count + CNT_W'(1);
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one combinational 4-bit adder/subtractor datapath (operands A, B plus subtract flag driven as carry-in/B-invert) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin FSM grants one requester, registers its operands onto the shared datapath, captures the WIDTH+1-bit result and returns it to the granted requester.
- Sits between board-level front ends (switch/UART decoders) and the single adder instance; also maintains a completed-operation counter for display.

Parameters:
- WIDTH, 4, operand width in bits; result is WIDTH+1 bits.
- CNT_W, 8, width of completed-operation counter.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_a, req0_b  in  WIDTH each  requester 0 operands.
- req0_sub  in  1  requester 0: 1 = subtract (A-B), 0 = add.
- req0_ready  out  1  requester 0 request accepted this cycle.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_result  out  WIDTH+1  requester 0 result; MSB = carry-out.
- rsp0_ready  in  1  requester 0 consumes result.
- req1_*, rsp1_*  same set as requester 0, for requester 1.
- au_a, au_b  out  WIDTH each  operands to shared adder.
- au_sub  out  1  to shared adder carry-in / B-invert.
- au_result  in  WIDTH+1  shared adder output, combinational from au_*.
- busy  out  1  FSM not in IDLE.
- grant_id  out  1  requester owning current/last operation.
- op_count  out  CNT_W  completed operations, wraps.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; au_a/au_b/au_sub=0; result register=0; rsp*_valid=0; grant_id=0; last_grant=1 (req0 wins first tie); op_count=0.
- Any in-flight operation is dropped and no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = requester with valid high; if both valid, the one != last_grant.
  - reqN_ready is combinational = (state==IDLE) & grantN; the handshake occurs in the same cycle.
  - On handshake: latch a/b/sub into operand regs, set grant_id=N and last_grant=N, go EXEC.
  - With no valid, stay in IDLE and keep all ready low.
- EXEC (1 cycle): au_* are driven from operand regs; capture au_result into result reg at end of cycle; go RESP.
- RESP:
  - rsp<grant_id>_valid=1 and rsp<grant_id>_result=result reg, held stable until rsp<grant_id>_ready=1.
  - On that edge: valid drops, op_count increments (wraps 2^CNT_W-1 -> 0), go IDLE.
- Latency and throughput: accept at cycle T, au_* valid T+1, rspN_valid at T+2. Minimum 3 cycles per op with rsp_ready held high.
- Non-granted response outputs: rspN_valid=0, rspN_result=0.
- au_* change only on accept; they hold the last operands in IDLE/RESP. No glitching on the datapath.
- Requests asserted during EXEC/RESP: ready stays low. The requester must hold valid and operands stable until ready; the bench asserts this.
- rsp_ready high outside RESP, or on the non-granted side: ignored.
- Result semantics (computed by the datapath, not re-checked here):
  - add: a+b.
  - sub: a+~b+1, where MSB=1 means no borrow.
- Back-to-back contention: alternates 0,1,0,1 strictly when both valid continuously.
- Reset asserted mid-EXEC or mid-RESP: immediate return to reset values. The response is lost and the requester must reissue.

Decomposition:
- Shared package addsub_pkg:
  - state encoding localparams IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - default WIDTH=4, CNT_W=8;
  - requester ID constants REQ0=1'b0, REQ1=1'b1.
- One sub-module, rr_arbiter2: combinational 2-way round-robin grant from (valid0, valid1, last_grant), with a registered last_grant updated on an enable.
- FSM, operand/result registers and op_count stay in addsub_arbiter.

Test Plan:
- Reset then req0 a=5 b=3 sub=0, rsp0_ready=1 -> req0_ready same cycle; au_a=5 au_b=3 au_sub=0 next cycle; rsp0_valid two cycles after accept with rsp0_result=5'h08; op_count=1.
- req1 a=3 b=5 sub=1 -> rsp1_result=5'h0E (borrow, MSB 0); then req1 a=9 b=4 sub=1 -> 5'h15; grant_id=1 both times.
- Both requesters valid continuously, each issuing 4 ops, rsp ready high -> grant order 0,1,0,1,0,1,0,1; each accept exactly 3 cycles apart; op_count=8.
- rsp0_ready held low for 5 cycles with a=15 b=1 add -> rsp0_valid and result 5'h10 stable throughout; req1_valid high meanwhile gets no ready until the cycle after rsp0 handshake.
- RESET_N pulsed low during EXEC -> all outputs to reset values asynchronously; no rsp valid afterward; op_count=0; the next request completes normally with req0 winning a tie.
- Drive op_count to 255 with back-to-back ops -> the next completion gives op_count=0.
